// File: rtl/kypd_pkg.sv
// kypd_pkg
// Shared definitions for the keypad move filter: key-code constants,
// the press/release FSM state encoding, the move command record, and a
// helper that classifies column keys.
package kypd_pkg;

  localparam logic [3:0] KEY_POP  = 4'hA;
  localparam logic [3:0] KEY_CLR0 = 4'h0;
  localparam logic [3:0] KEY_CLRF = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  typedef struct packed {
    logic [2:0] col;
    logic       pop;
  } move_t;

  // Column keys are 1..num_cols; key 0 is a clear key, not a column.
  function automatic logic is_col_key(input logic [3:0] code, input int num_cols);
    return (code != 4'd0) && (int'(code) <= num_cols);
  endfunction

endpackage

// File: rtl/stable_counter.sv
// stable_counter
// Registers the decoder's {key_valid, key_code} once, compares each new
// sample with the previous one, and counts consecutive identical samples.
// The count saturates at STABLE_CYCLES-1, which raises 'stable'.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   key_valid     - raw key-held level from the decoder
//   key_code      - raw key code from the decoder
//   sample_valid  - registered key_valid
//   sample_code   - registered key_code
//   stable        - sample has held unchanged for STABLE_CYCLES-1 compares
module stable_counter #(
  parameter int STABLE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       sample_valid,
  output logic [3:0] sample_code,
  output logic       stable
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             prev_valid;
  logic [3:0]       prev_code;
  logic [CNT_W-1:0] cnt;

  // Sample pipeline plus run-length counter. Any difference between the
  // newest and previous sample restarts the run; the count holds at its
  // maximum so it can never wrap back into an "unstable" value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample_code  <= 4'd0;
      prev_valid   <= 1'b0;
      prev_code    <= 4'd0;
      cnt          <= '0;
    end else begin
      sample_valid <= key_valid;
      sample_code  <= key_code;
      prev_valid   <= sample_valid;
      prev_code    <= sample_code;
      if ({sample_valid, sample_code} == {prev_valid, prev_code}) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/keypad_move_filter.sv
// keypad_move_filter
// Turns debounced keypad presses into single move commands (drop or pop
// into a column) for the game controller, and owns the pop-armed mode
// toggled by key A.
//
// Ports:
//   clk, rst      - 100 MHz clock, synchronous active-high reset
//   key_code      - decoder key code
//   key_valid     - decoder key-held level
//   move_ready    - controller accepts the pending move this cycle
//   move_valid    - move command pending
//   move_col      - zero-based column (key 1 -> 0)
//   move_pop      - 1 = pop from bottom, 0 = drop
//   pop_armed     - pop mode armed
//   move_dropped  - one-cycle pulse: a column press was discarded
module keypad_move_filter
  import kypd_pkg::*;
#(
  parameter int STABLE_CYCLES = 2_000_000,
  parameter int NUM_COLS      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic       move_pop,
  output logic       pop_armed,
  output logic       move_dropped
);

  logic       sample_valid;
  logic [3:0] sample_code;
  logic       stable;

  state_t state, next_state;
  logic   press;
  move_t  move_q;

  stable_counter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stable (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .sample_valid(sample_valid),
    .sample_code (sample_code),
    .stable      (stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // 'press' fires exactly once per debounced key-down; HELD swallows any
  // code changes so a held key can never trigger a second action.
  always_comb begin
    next_state = state;
    press      = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) next_state = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sample_valid) begin
          next_state = IDLE;
        end else if (stable) begin
          press      = 1'b1;
          next_state = HELD;
        end
      end
      HELD: begin
        if (!sample_valid) next_state = REL_WAIT;
      end
      REL_WAIT: begin
        if (sample_valid) begin
          next_state = HELD;
        end else if (stable) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Move register and pop mode. A completed handshake clears move_valid,
  // but a press in the same cycle overrides that and loads the new move.
  // A column press that finds a move still pending is thrown away and
  // leaves pop_armed alone so the player's armed pop is not lost.
  // Subtracting on the low 3 bits gives code-1 for codes 1..8.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_valid   <= 1'b0;
      move_q       <= '0;
      pop_armed    <= 1'b0;
      move_dropped <= 1'b0;
    end else begin
      move_dropped <= 1'b0;
      if (move_valid && move_ready) begin
        move_valid <= 1'b0;
      end
      if (press) begin
        if (is_col_key(sample_code, NUM_COLS)) begin
          if (move_valid && !move_ready) begin
            move_dropped <= 1'b1;
          end else begin
            move_valid <= 1'b1;
            move_q.col <= sample_code[2:0] - 3'd1;
            move_q.pop <= pop_armed;
            pop_armed  <= 1'b0;
          end
        end else if (sample_code == KEY_POP) begin
          pop_armed <= !pop_armed;
        end else if (sample_code == KEY_CLR0 || sample_code == KEY_CLRF) begin
          pop_armed <= 1'b0;
        end
      end
    end
  end

  assign move_col = move_q.col;
  assign move_pop = move_q.pop;

endmodule

// File: tb/tb_keypad_move_filter.sv
// tb_keypad_move_filter
// Directed bench for keypad_move_filter with STABLE_CYCLES=4, NUM_COLS=7.
// Stimulus pushes each expected move into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever a handshake occurs.
module tb_keypad_move_filter;

  localparam int STABLE = 4;
  localparam int COLS   = 7;
  localparam int LAT    = STABLE + 2;

  typedef struct {
    logic [2:0] col;
    logic       pop;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic       move_ready;
  logic       move_valid;
  logic [2:0] move_col;
  logic       move_pop;
  logic       pop_armed;
  logic       move_dropped;

  exp_t sb[$];
  int   n_checks;
  int   n_fails;
  int   moves_seen;
  int   drops_seen;
  bit   hold_pend;
  logic [2:0] held_col;
  logic       held_pop;

  keypad_move_filter #(
    .STABLE_CYCLES(STABLE),
    .NUM_COLS     (COLS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .move_ready  (move_ready),
    .move_valid  (move_valid),
    .move_col    (move_col),
    .move_pop    (move_pop),
    .pop_armed   (pop_armed),
    .move_dropped(move_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] code, input int hold, input int rel);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) tick();
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (rel) tick();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " move_valid"}, move_valid, 0);
    checkOutput({tag, " move_col"}, move_col, 0);
    checkOutput({tag, " move_pop"}, move_pop, 0);
    checkOutput({tag, " pop_armed"}, pop_armed, 0);
    checkOutput({tag, " move_dropped"}, move_dropped, 0);
  endtask

  // Monitor: scoreboard compare on each handshake, plus a stability check
  // on col/pop while a move waits for the controller.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (move_dropped) drops_seen++;
      if (move_valid) begin
        if (hold_pend) begin
          checkOutput("pending col stable", move_col, held_col);
          checkOutput("pending pop stable", move_pop, held_pop);
        end
        if (move_ready) begin
          exp_t e;
          moves_seen++;
          checkOutput("scoreboard has expected move", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("move_col", move_col, e.col);
            checkOutput("move_pop", move_pop, e.pop);
          end
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          held_col  = move_col;
          held_pop  = move_pop;
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    bit found;
    bit prev_armed;
    int base;

    n_checks   = 0;
    n_fails    = 0;
    moves_seen = 0;
    drops_seen = 0;
    hold_pend  = 1'b0;
    rst        = 1'b1;
    key_valid  = 1'b0;
    key_code   = 4'd0;
    move_ready = 1'b1;

    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b0;
    repeat (4) tick();

    // Key 3: move_valid exactly on the LAT-th edge after key_valid rises.
    $display("[TB] key 3 latency and single action");
    sb.push_back('{3'd2, 1'b0});
    key_code  = 4'd3;
    key_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("key3 move_valid edge %0d", i), move_valid, (i == LAT) ? 1 : 0);
    end
    repeat (12) tick();
    key_valid = 1'b0;
    repeat (10) tick();

    // Arm pop with A, then key 5 pops column 4 and disarms on the same edge.
    $display("[TB] pop armed then key 5");
    applyStimulus(4'hA, 8, 8);
    checkOutput("A arms pop", pop_armed, 1);
    sb.push_back('{3'd4, 1'b1});
    key_code   = 4'd5;
    key_valid  = 1'b1;
    found      = 1'b0;
    prev_armed = pop_armed;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (move_valid) begin
        found = 1'b1;
        checkOutput("pop_armed before move edge", prev_armed, 1);
        checkOutput("pop_armed cleared with move", pop_armed, 0);
      end
      prev_armed = pop_armed;
    end
    checkOutput("key5 move appeared", found, 1);
    repeat (4) tick();
    key_valid = 1'b0;
    repeat (8) tick();

    // Key 2 bouncing every 2 cycles produces nothing, then one clean move.
    $display("[TB] key 2 bounce");
    base     = moves_seen;
    key_code = 4'd2;
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      repeat (2) tick();
      key_valid = 1'b0;
      repeat (2) tick();
    end
    checkOutput("no move during bounce", moves_seen, base);
    sb.push_back('{3'd1, 1'b0});
    applyStimulus(4'd2, 10, 10);
    checkOutput("one move after bounce", moves_seen, base + 1);

    // Controller stalled: key 1 pends, A arms, key 6 is dropped.
    $display("[TB] stalled controller");
    move_ready = 1'b0;
    sb.push_back('{3'd0, 1'b0});
    applyStimulus(4'd1, 8, 8);
    checkOutput("key1 pending", move_valid, 1);
    checkOutput("key1 col", move_col, 0);
    applyStimulus(4'hA, 8, 8);
    checkOutput("A arms while pending", pop_armed, 1);
    base = drops_seen;
    applyStimulus(4'd6, 8, 8);
    checkOutput("key6 dropped pulses", drops_seen - base, 1);
    checkOutput("pop_armed kept on drop", pop_armed, 1);
    checkOutput("key1 still pending", move_valid, 1);
    checkOutput("pending col unchanged", move_col, 0);
    move_ready = 1'b1;
    repeat (2) tick();
    checkOutput("move_valid falls after handshake", move_valid, 0);
    repeat (5) tick();
    checkOutput("no col5 move", move_valid, 0);
    applyStimulus(4'hF, 8, 8);
    checkOutput("F clears pop", pop_armed, 0);

    // Non-column keys leave pop mode alone; A then F toggles 1 then 0.
    $display("[TB] non-column keys");
    base = moves_seen;
    applyStimulus(4'hA, 8, 8);
    checkOutput("A arms", pop_armed, 1);
    applyStimulus(4'd9, 8, 8);
    checkOutput("key9 pop unchanged", pop_armed, 1);
    applyStimulus(4'd8, 8, 8);
    checkOutput("key8 pop unchanged", pop_armed, 1);
    applyStimulus(4'hB, 8, 8);
    checkOutput("keyB pop unchanged", pop_armed, 1);
    checkOutput("no move from 9/8/B", moves_seen, base);
    checkOutput("no pending from 9/8/B", move_valid, 0);
    applyStimulus(4'hF, 8, 8);
    checkOutput("F clears", pop_armed, 0);

    // Reset while HELD with a move pending; held key re-accepted afterwards.
    $display("[TB] reset mid-operation");
    move_ready = 1'b0;
    key_code   = 4'd4;
    key_valid  = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (move_valid) found = 1'b1;
    end
    checkOutput("key4 pending before reset", found, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkAllZero("after reset edge");
    tick();
    rst        = 1'b0;
    move_ready = 1'b1;
    sb.push_back('{3'd3, 1'b0});
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("post-reset move_valid edge %0d", i), move_valid, (i == LAT) ? 1 : 0);
    end
    key_valid = 1'b0;
    repeat (10) tick();

    checkOutput("scoreboard drained", sb.size(), 0);
    checkOutput("total moves", moves_seen, 5);
    checkOutput("total drops", drops_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/keypad_move_filter.md
# keypad_move_filter

Downstream consumer of the keypad scanner/decoder in the Connect-4 pop design. It takes the decoder's key code and key-held level, debounces them, and detects the press edge. Each press becomes exactly one move command (drop or pop into a column), sent to the game controller over a valid/ready handshake. It also owns the "pop armed" mode toggled by key A, replacing the decoder's sticky `pop_out`/`btn_clk` flags with clean single-event semantics.

## Interface
Parameters:
- `STABLE_CYCLES`, default 2_000_000: consecutive identical samples required to accept a press or release (20 ms at 100 MHz); legal range ≥ 2.
- `NUM_COLS`, default 7: number of board columns; keys 1..NUM_COLS are legal; must be ≤ 8.

Ports:
- `clk`  in  1: 100 MHz system clock.
- `rst`  in  1: synchronous, active-high reset.
- `key_code`  in  4: hex code of the key currently seen by the decoder.
- `key_valid`  in  1: high while the decoder sees a key held.
- `move_ready`  in  1: game controller accepts the move this cycle.
- `move_valid`  out  1: move command pending.
- `move_col`  out  3: zero-based column (key 1 maps to 0).
- `move_pop`  out  1: 1 = pop from bottom, 0 = drop.
- `pop_armed`  out  1: pop mode is armed (for LED/display).
- `move_dropped`  out  1: one-cycle pulse; a legal column press was discarded because a move was still pending.

## Operation
- Inputs are registered once (`key_valid`, `key_code`). All decisions use the registered sample.
- Debounce counter: counts cycles where the registered {valid, code} equals the previous registered value. Any change clears it to 0. It saturates at STABLE_CYCLES-1.
- FSM states:
  - IDLE: waiting for a key. On sampled valid=1, go to PRESS_WAIT.
  - PRESS_WAIT: if valid drops, return to IDLE. If the counter reaches STABLE_CYCLES-1, perform the press action and go to HELD.
  - HELD: if the sample changes to valid=0, go to REL_WAIT. A code change while still held is ignored; no second action.
  - REL_WAIT: if valid reasserts, go to HELD. If the counter reaches STABLE_CYCLES-1 with valid=0, go to IDLE.
- Press actions, decided by the accepted code:
  - 1..NUM_COLS: issue a move with `move_col = code-1` and `move_pop = pop_armed`, then clear `pop_armed`.
  - 0xA: toggle `pop_armed`.
  - 0x0 or 0xF: clear `pop_armed`.
  - Any other code, including column keys above NUM_COLS: no action.
- Handshake:
  - `move_valid` rises with the move and holds `move_col` and `move_pop` stable until the cycle `move_valid && move_ready`; it falls on the next edge.
  - A new column press while `move_valid` is high: the move is discarded, `move_dropped` pulses for 1 cycle, and `pop_armed` is left unchanged.
  - A press accepted in the same cycle as a handshake completes: the handshake completes first and the new move loads, so `move_valid` stays high with the new data.
- No auto-repeat: holding a key produces exactly one action.

## Timing
- Reset values: `move_valid`=0, `move_col`=0, `move_pop`=0, `pop_armed`=0, `move_dropped`=0. FSM goes to IDLE, counter to 0, sample registers to 0.
- Latency:
  - `key_valid` rises (code constant) at edge N → `move_valid` is high after edge N+STABLE_CYCLES+1.
  - `pop_armed` toggles on that same edge.
- A glitch shorter than STABLE_CYCLES during PRESS_WAIT or REL_WAIT produces no action.
- Reset mid-operation discards any pending move and debounce state. The first edge after reset deasserts all outputs.
- The counter width is derived from STABLE_CYCLES (ceil log2). It never wraps.

## Structure
- Shared package `kypd_pkg`:
  - key-code constants: `KEY_POP`=4'hA, `KEY_CLR0`=4'h0, `KEY_CLRF`=4'hF;
  - the FSM state enum {IDLE, PRESS_WAIT, HELD, REL_WAIT};
  - a move struct {col[2:0], pop}.
- One sub-module, `stable_counter`: registered sample compare, saturating counter, and a `stable` flag. The FSM and handshake stay in the top module.

## Test plan (STABLE_CYCLES=4, NUM_COLS=7)
- Key 3 held 20 cycles, `move_ready`=1 → exactly one `move_valid` pulse at the computed edge, `move_col`=2, `move_pop`=0.
- Key A held/released, then key 5, `move_ready`=1 → `pop_armed` rises; move `move_col`=4, `move_pop`=1; `pop_armed` returns to 0 on the same edge.
- Key 2 bouncing (valid toggles every 2 cycles for 12 cycles), then stable → exactly one move, `move_col`=1.
- `move_ready`=0: key 1, release, key 6 → first move held (`move_col`=0); `move_dropped` pulses once; after `move_ready`=1, `move_valid` falls and no col 5 move appears.
- Key 9, key 8, key B → no move; `pop_armed` unchanged. Key A, then key F → `pop_armed` 1 then 0.
- `rst` asserted while in HELD with `move_valid` high → next edge all outputs 0. A key still held after reset is accepted after STABLE_CYCLES.
